// File: rtl/seq_det_pkg.sv
// Shared defaults and mode constants for the parameterised serial pattern detector.
package seq_det_pkg;

    localparam int unsigned SEQ_LEN_DEF = 4;
    localparam logic [3:0]  PATTERN_DEF = 4'b1001;
    localparam int unsigned CNT_W_DEF   = 8;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

endpackage

// File: rtl/fsm_seq_detect_param.sv
// Serial pattern detector with loadable pattern and overlapping/non-overlapping modes.
// Optional saturating match counter is enabled by defining SEQ_DET_MATCH_CNT_EN.
module fsm_seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter     PATTERN = PATTERN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ser_in,
    input  logic               ser_vld,
    input  logic               ovl_mode,
    input  logic               pat_ld,
    input  logic [SEQ_LEN-1:0] pat_in,
    output logic               out
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_seq_len
        $error("fsm_seq_detect_param: SEQ_LEN must be in 2..16");
    end
    if ($bits(PATTERN) != SEQ_LEN) begin : g_bad_pattern_width
        $error("fsm_seq_detect_param: PATTERN width must equal SEQ_LEN");
    end

    localparam int                 FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0]  MATCH_MIN = FILL_W'(SEQ_LEN - 1);
    localparam logic [SEQ_LEN-1:0] PAT_RST   = SEQ_LEN'(PATTERN);

    logic [SEQ_LEN-1:0] hist;
    logic [SEQ_LEN-1:0] pat;
    logic [FILL_W-1:0]  fill;

    logic [SEQ_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill_inc;
    logic               accept;
    logic               match;

    // Fill gating keeps stale history (or an all-zero pattern) from matching early.
    always_comb begin
        hist_next = {hist[SEQ_LEN-2:0], ser_in};
        fill_inc  = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
        accept    = ser_vld && !pat_ld;
        match     = accept && (fill >= MATCH_MIN) && (hist_next == pat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            pat  <= PAT_RST;
            out  <= 1'b0;
        end else begin
            out <= match;
            if (pat_ld) begin
                pat  <= pat_in;
                fill <= '0;
            end else if (ser_vld) begin
                hist <= hist_next;
                if (match && ovl_mode == OVL_OFF) begin
                    fill <= '0;
                end else begin
                    fill <= fill_inc;
                end
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (pat_ld) begin
            match_cnt <= '0;
        end else if (match && match_cnt != '1) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
